// File: rtl/adc_lut_pkg.sv
// Shared definitions for the ADC power lookup block.
// Holds the controller state encoding, the default datapath widths and
// the full-scale power constant for the default output width.
package adc_lut_pkg;

  localparam int unsigned DEF_N_PTS = 5;
  localparam int unsigned DEF_DW    = 10;
  localparam int unsigned DEF_PW    = 10;
  localparam int unsigned DEF_SW    = 12;
  localparam int unsigned DEF_SFRAC = 8;

  // Largest representable power code at the default output width.
  localparam int unsigned MAX_PWR = (1 << DEF_PW) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StCalc,
    StOut
  } state_e;

endpackage

// File: rtl/adc_seg_interp.sv
// Single-segment linear interpolation datapath.
// Computes pwr_base + ((slope * (sample - volt)) >>> SFRAC) and clamps the
// result into the unsigned PW-bit output range.
//   sample   : ADC sample (assumed >= volt)
//   volt     : segment start voltage
//   pwr_base : power at the segment start
//   slope    : signed slope, SFRAC fractional bits
//   pwr      : clamped interpolated power
//   sat      : high when the clamp was applied
module adc_seg_interp #(
  parameter int unsigned DW    = 10,
  parameter int unsigned PW    = 10,
  parameter int unsigned SW    = 12,
  parameter int unsigned SFRAC = 8
) (
  input  logic [DW-1:0]        sample,
  input  logic [DW-1:0]        volt,
  input  logic [PW-1:0]        pwr_base,
  input  logic signed [SW-1:0] slope,
  output logic [PW-1:0]        pwr,
  output logic                 sat
);

  localparam int unsigned ProdW = SW + DW + 1;
  localparam int unsigned SumW  = ProdW + 1;

  localparam logic signed [SumW-1:0] MaxS = {{(SumW-PW){1'b0}}, {PW{1'b1}}};

  logic [DW-1:0]            delta;
  logic signed [ProdW-1:0]  prod;
  logic signed [ProdW-1:0]  term;
  logic signed [SumW-1:0]   sum;

  always_comb begin
    delta = sample - volt;
    // Delta is unsigned: zero-extend it, sign-extend the slope.
    prod  = $signed({{(DW+1){slope[SW-1]}}, slope}) * $signed({{SW{1'b0}}, 1'b0, delta});
    term  = prod >>> SFRAC;
    sum   = $signed({term[ProdW-1], term}) + $signed({{(SumW-PW){1'b0}}, pwr_base});
    pwr   = sum[PW-1:0];
    sat   = 1'b0;
    if (sum < 0) begin
      pwr = '0;
      sat = 1'b1;
    end else if (sum > MaxS) begin
      pwr = '1;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/adc_power_lut.sv
// Piecewise-linear ADC sample to power converter.
// Accepts one sample at a time, walks the breakpoint table to find its
// segment, interpolates, and holds the result on a valid/ready output.
//   clk, rst     : clock, synchronous active-high reset
//   s_*          : sample input stream (data + channel tag)
//   cfg_*        : breakpoint table write port, honoured only when idle
//   m_*          : result stream (power, channel, segment, flags)
//   busy         : controller not idle
module adc_power_lut
  import adc_lut_pkg::*;
#(
  parameter int unsigned N_PTS = DEF_N_PTS,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned SFRAC = DEF_SFRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  input  logic [2:0]           s_chan,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [DW-1:0]        cfg_volt,
  input  logic [PW-1:0]        cfg_pwr,
  input  logic signed [SW-1:0] cfg_slope,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PW-1:0]        m_pwr,
  output logic [2:0]           m_chan,
  output logic [2:0]           m_seg,
  output logic                 m_under,
  output logic                 m_over,
  output logic                 m_sat,
  output logic                 busy
);

  // Storage is always 8 deep so any 3-bit index is in range; entries at or
  // above N_PTS are never written and stay zero.
  localparam int unsigned    TblDepth = 8;
  localparam logic [2:0]     LastIdx  = 3'(N_PTS - 1);

  state_e state_q, state_d;

  logic [DW-1:0]        volt_q  [TblDepth];
  logic [DW-1:0]        volt_d  [TblDepth];
  logic [PW-1:0]        pwr_q   [TblDepth];
  logic [PW-1:0]        pwr_d   [TblDepth];
  logic signed [SW-1:0] slope_q [TblDepth];
  logic signed [SW-1:0] slope_d [TblDepth];

  logic [DW-1:0] sample_q, sample_d;
  logic [2:0]    chan_q, chan_d;
  logic [2:0]    k_q, k_d, k_nxt;
  logic          under_q, under_d;

  logic          m_valid_q, m_valid_d;
  logic [PW-1:0] m_pwr_q, m_pwr_d;
  logic [2:0]    m_chan_q, m_chan_d;
  logic [2:0]    m_seg_q, m_seg_d;
  logic          m_under_q, m_under_d;
  logic          m_over_q, m_over_d;
  logic          m_sat_q, m_sat_d;

  logic [PW-1:0] interp_pwr;
  logic          interp_sat;

  adc_seg_interp #(
    .DW    (DW),
    .PW    (PW),
    .SW    (SW),
    .SFRAC (SFRAC)
  ) u_interp (
    .sample   (sample_q),
    .volt     (volt_q[k_q]),
    .pwr_base (pwr_q[k_q]),
    .slope    (slope_q[k_q]),
    .pwr      (interp_pwr),
    .sat      (interp_sat)
  );

  assign s_ready = (state_q == StIdle);
  assign busy    = (state_q != StIdle);
  assign m_valid = m_valid_q;
  assign m_pwr   = m_pwr_q;
  assign m_chan  = m_chan_q;
  assign m_seg   = m_seg_q;
  assign m_under = m_under_q;
  assign m_over  = m_over_q;
  assign m_sat   = m_sat_q;

  always_comb begin
    state_d   = state_q;
    volt_d    = volt_q;
    pwr_d     = pwr_q;
    slope_d   = slope_q;
    sample_d  = sample_q;
    chan_d    = chan_q;
    k_d       = k_q;
    k_nxt     = k_q + 3'd1;
    under_d   = under_q;
    m_valid_d = m_valid_q;
    m_pwr_d   = m_pwr_q;
    m_chan_d  = m_chan_q;
    m_seg_d   = m_seg_q;
    m_under_d = m_under_q;
    m_over_d  = m_over_q;
    m_sat_d   = m_sat_q;

    unique case (state_q)
      StIdle: begin
        // Table write lands on the same edge as the capture, so the
        // captured sample already searches the updated entry.
        if (cfg_we && (cfg_addr <= LastIdx)) begin
          volt_d[cfg_addr]  = cfg_volt;
          pwr_d[cfg_addr]   = cfg_pwr;
          slope_d[cfg_addr] = cfg_slope;
        end
        if (s_valid) begin
          sample_d = s_data;
          chan_d   = s_chan;
          k_d      = 3'd0;
          under_d  = 1'b0;
          state_d  = StSearch;
        end
      end

      StSearch: begin
        if ((k_q == 3'd0) && (sample_q < volt_q[0])) begin
          under_d = 1'b1;
          state_d = StCalc;
        end else if ((k_q == LastIdx) || (volt_q[k_nxt] > sample_q)) begin
          state_d = StCalc;
        end else begin
          k_d = k_nxt;
        end
      end

      StCalc: begin
        m_valid_d = 1'b1;
        m_chan_d  = chan_q;
        m_seg_d   = under_q ? 3'd0 : k_q;
        m_under_d = under_q;
        m_over_d  = 1'b0;
        m_sat_d   = 1'b0;
        if (under_q) begin
          m_pwr_d = pwr_q[0];
        end else if ((k_q == LastIdx) && (sample_q > volt_q[k_q])) begin
          m_pwr_d  = pwr_q[k_q];
          m_over_d = 1'b1;
        end else begin
          m_pwr_d = interp_pwr;
          m_sat_d = interp_sat;
        end
        state_d = StOut;
      end

      StOut: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sample_q  <= '0;
      chan_q    <= '0;
      k_q       <= '0;
      under_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_pwr_q   <= '0;
      m_chan_q  <= '0;
      m_seg_q   <= '0;
      m_under_q <= 1'b0;
      m_over_q  <= 1'b0;
      m_sat_q   <= 1'b0;
      for (int i = 0; i < int'(TblDepth); i++) begin
        volt_q[i]  <= '0;
        pwr_q[i]   <= '0;
        slope_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      chan_q    <= chan_d;
      k_q       <= k_d;
      under_q   <= under_d;
      m_valid_q <= m_valid_d;
      m_pwr_q   <= m_pwr_d;
      m_chan_q  <= m_chan_d;
      m_seg_q   <= m_seg_d;
      m_under_q <= m_under_d;
      m_over_q  <= m_over_d;
      m_sat_q   <= m_sat_d;
      volt_q    <= volt_d;
      pwr_q     <= pwr_d;
      slope_q   <= slope_d;
    end
  end

endmodule

// File: tb/tb_adc_power_lut.sv
// Bench for adc_power_lut: directed table/sample scenarios followed by
// randomized tables and samples, all compared against a table-walk model.
module tb_adc_power_lut;

  localparam int N = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [9:0]        s_data;
  logic [2:0]        s_chan;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [9:0]        cfg_volt;
  logic [9:0]        cfg_pwr;
  logic signed [11:0] cfg_slope;
  logic              m_valid;
  logic              m_ready;
  logic [9:0]        m_pwr;
  logic [2:0]        m_chan;
  logic [2:0]        m_seg;
  logic              m_under;
  logic              m_over;
  logic              m_sat;
  logic              busy;

  int nchecks = 0;
  int nerr    = 0;

  int tv [N];
  int tp [N];
  int ts [N];

  adc_power_lut dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_chan    (s_chan),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_volt  (cfg_volt),
    .cfg_pwr   (cfg_pwr),
    .cfg_slope (cfg_slope),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_pwr     (m_pwr),
    .m_chan    (m_chan),
    .m_seg     (m_seg),
    .m_under   (m_under),
    .m_over    (m_over),
    .m_sat     (m_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", nerr);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Segment = last breakpoint not above the sample; interpolate with floor
  // division by 256, then clamp to 0..1023.
  function automatic void ref_model(input int s, output int p, output int seg,
                                    output int un, output int ov, output int sat);
    int term;
    int sum;
    un = 0; ov = 0; sat = 0; seg = 0; p = 0;
    if (s < tv[0]) begin
      un = 1;
      p  = tp[0];
      return;
    end
    for (int i = 0; i < N; i++) if (tv[i] <= s) seg = i;
    if (seg == N - 1 && s > tv[seg]) begin
      ov = 1;
      p  = tp[seg];
      return;
    end
    term = (ts[seg] * (s - tv[seg])) >>> 8;
    sum  = tp[seg] + term;
    if (sum < 0) begin
      p = 0; sat = 1;
    end else if (sum > 1023) begin
      p = 1023; sat = 1;
    end else begin
      p = sum;
    end
  endfunction

  task automatic cfg_write(input int a, input int v, input int p, input int sl);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a[2:0];
    cfg_volt  = v[9:0];
    cfg_pwr   = p[9:0];
    cfg_slope = sl[11:0];
    @(negedge clk);
    cfg_we = 1'b0;
    if (a < N) begin
      tv[a] = v; tp[a] = p; ts[a] = sl;
    end
  endtask

  // One sample transaction; optional table write in the handshake cycle and
  // optional output stall with a write attempt that must be ignored.
  task automatic run_sample(input int s, input int ch, input int stall,
                            input bit cw, input int ca, input int cv,
                            input int cp, input int cs);
    int ep, es, eu, eo, esat, lat, elat;
    @(negedge clk);
    chk("s_ready_idle", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = s[9:0];
    s_chan  = ch[2:0];
    if (cw) begin
      cfg_we = 1'b1; cfg_addr = ca[2:0]; cfg_volt = cv[9:0];
      cfg_pwr = cp[9:0]; cfg_slope = cs[11:0];
    end
    @(negedge clk);
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    if (cw && ca < N) begin
      tv[ca] = cv; tp[ca] = cp; ts[ca] = cs;
    end
    ref_model(s, ep, es, eu, eo, esat);
    elat = eu ? 3 : 3 + es;
    lat = 1;
    while (m_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("m_valid", 32'(m_valid), 1);
    chk("m_pwr", 32'(m_pwr), ep);
    chk("m_seg", 32'(m_seg), es);
    chk("m_chan", 32'(m_chan), ch);
    chk("m_under", 32'(m_under), eu);
    chk("m_over", 32'(m_over), eo);
    chk("m_sat", 32'(m_sat), esat);
    chk("s_ready_out", 32'(s_ready), 0);
    chk("busy_out", 32'(busy), 1);
    if (stall > 0) begin
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_volt = 10'd5;
      cfg_pwr = 10'd999; cfg_slope = 12'sd7;
      repeat (stall) begin
        @(negedge clk);
        cfg_we = 1'b0;
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_pwr", 32'(m_pwr), ep);
        chk("stall_chan", 32'(m_chan), ch);
        chk("stall_s_ready", 32'(s_ready), 0);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_drop", 32'(m_valid), 0);
    chk("s_ready_back", 32'(s_ready), 1);
  endtask

  initial begin
    int v;
    int s;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_chan = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_volt = '0; cfg_pwr = '0; cfg_slope = '0; m_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      tv[i] = 0; tp[i] = 0; ts[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_pwr", 32'(m_pwr), 0);
    chk("rst_m_chan", 32'(m_chan), 0);
    chk("rst_m_seg", 32'(m_seg), 0);
    chk("rst_flags", 32'({m_under, m_over, m_sat}), 0);

    cfg_write(0, 0, 0, 128);
    cfg_write(1, 200, 100, 256);
    cfg_write(2, 400, 300, 384);
    cfg_write(3, 600, 600, 512);
    cfg_write(4, 800, 1000, 0);
    cfg_write(6, 10, 10, 10);  // out-of-range address, ignored

    run_sample(300, 2, 0, 1'b0, 0, 0, 0, 0);
    run_sample(800, 5, 0, 1'b0, 0, 0, 0, 0);
    run_sample(900, 1, 0, 1'b0, 0, 0, 0, 0);
    cfg_write(0, 50, 0, 128);
    run_sample(10, 3, 0, 1'b0, 0, 0, 0, 0);
    cfg_write(3, 600, 600, 2047);
    run_sample(799, 4, 0, 1'b0, 0, 0, 0, 0);
    run_sample(300, 6, 5, 1'b0, 0, 0, 0, 0);
    run_sample(300, 7, 0, 1'b0, 0, 0, 0, 0);
    run_sample(500, 0, 0, 1'b1, 2, 400, 350, -256);
    run_sample(700, 2, 0, 1'b1, 3, 600, 100, -2048);

    // Reset while the controller is searching.
    @(negedge clk);
    s_valid = 1'b1; s_data = 10'd300; s_chan = 3'd1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("busy_search", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_s_ready", 32'(s_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    for (int i = 0; i < N; i++) begin
      tv[i] = 0; tp[i] = 0; ts[i] = 0;
    end
    run_sample(300, 2, 0, 1'b0, 0, 0, 0, 0);

    for (int it = 0; it < 32; it++) begin
      if (it % 4 == 0) begin
        v = $urandom_range(0, 100);
        for (int i = 0; i < N; i++) begin
          if (v > 1023) v = 1023;
          cfg_write(i, v, $urandom_range(0, 1023), int'($urandom_range(0, 4095)) - 2048);
          v += $urandom_range(0, 250);
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        s = tv[$urandom_range(0, N - 1)] + int'($urandom_range(0, 2)) - 1;
        if (s < 0) s = 0;
        if (s > 1023) s = 1023;
      end else begin
        s = $urandom_range(0, 1023);
      end
      run_sample(s, $urandom_range(0, 7), $urandom_range(0, 2), 1'b0, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
